tdm_audio_mixer: RTL and testbench

TDM_AUDIO_MIXER -- requirements
Module: tdm_audio_mixer

---
 rtl/discrete_audio_pkg.sv | 16 +
 rtl/signed_saturator.sv | 24 ++
 rtl/tdm_audio_mixer.sv | 139 +++++++++++++
 tb/tb_tdm_audio_mixer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/discrete_audio_pkg.sv
// Shared constants and the mixer state encoding for the discrete audio blocks.
package discrete_audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int GAIN_ONE   = 16384;
  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    ROUND  = 2'd2,
    OUTPUT = 2'd3
  } mix_state_e;

endpackage

// File: rtl/signed_saturator.sv
// Combinational clamp of a wide signed value into the 16-bit sample range.
module signed_saturator
  import discrete_audio_pkg::*;
#(
  parameter int IN_W = 20
) (
  input  logic signed [IN_W-1:0]     din_i,
  output logic signed [SAMPLE_W-1:0] dout_o
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(SAMPLE_MAX);
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(SAMPLE_MIN);

  always_comb begin
    if (din_i > MAX_V) begin
      dout_o = SAMPLE_W'(SAMPLE_MAX);
    end else if (din_i < MIN_V) begin
      dout_o = SAMPLE_W'(SAMPLE_MIN);
    end else begin
      dout_o = din_i[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/tdm_audio_mixer.sv
// Time-multiplexed N-channel gain mixer: one shared 16x16 multiplier walks the
// channels after each sample strobe, then rounds, clamps and publishes the mix.
module tdm_audio_mixer
  import discrete_audio_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int GAIN_FRAC_BITS = 14
) (
  input  logic                                 clk,
  input  logic                                 I_RSTn,
  input  logic                                 audio_clk_en,
  input  logic [NUM_CHANNELS*SAMPLE_W-1:0]     in,
  input  logic [NUM_CHANNELS*SAMPLE_W-1:0]     gain,
  output logic signed [SAMPLE_W-1:0]           out,
  output logic                                 out_valid,
  output logic                                 overrun
);

  // Headroom bits so the sum of NUM_CHANNELS full-scale products cannot wrap.
  localparam int ACC_W = 32 + $clog2(NUM_CHANNELS);
  localparam int IDX_W = $clog2(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  mix_state_e                  state_q, state_d;
  logic signed [SAMPLE_W-1:0]  in_q   [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0]  in_d   [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0]  gain_q [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0]  gain_d [NUM_CHANNELS];
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [SAMPLE_W-1:0]  res_q, res_d;
  logic signed [SAMPLE_W-1:0]  out_q, out_d;
  logic                        vld_q, vld_d;
  logic                        ovr_q, ovr_d;

  logic signed [31:0]          prod;
  logic signed [ACC_W-1:0]     prod_ext;
  logic signed [ACC_W-1:0]     rounded;
  logic signed [SAMPLE_W-1:0]  sat_out;

  function automatic logic signed [ACC_W-1:0] round_half_up(
    input logic signed [ACC_W-1:0] v
  );
    logic signed [ACC_W-1:0] half;
    half                   = '0;
    half[GAIN_FRAC_BITS-1] = 1'b1;
    return (v + half) >>> GAIN_FRAC_BITS;
  endfunction

  assign prod     = in_q[idx_q] * gain_q[idx_q];
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  assign rounded  = round_half_up(acc_q);

  signed_saturator #(.IN_W(ACC_W)) u_sat (
    .din_i  (rounded),
    .dout_o (sat_out)
  );

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    gain_d  = gain_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    ovr_d   = ovr_q;

    // A strobe while a sample is in flight (including the OUTPUT cycle) is dropped.
    if (audio_clk_en && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          for (int k = 0; k < NUM_CHANNELS; k++) begin
            in_d[k]   = in[SAMPLE_W*k +: SAMPLE_W];
            gain_d[k] = gain[SAMPLE_W*k +: SAMPLE_W];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ROUND;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ROUND: begin
        res_d   = sat_out;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        out_d   = res_q;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state_q <= IDLE;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        in_q[k]   <= '0;
        gain_q[k] <= '0;
      end
      acc_q <= '0;
      idx_q <= '0;
      res_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      gain_q  <= gain_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_tdm_audio_mixer.sv
// Bench for tdm_audio_mixer: transaction-level mix model checked every cycle,
// plus directed samples with hand-computed results.
module tb_tdm_audio_mixer;

  localparam int NCH = 4;
  localparam int LAT = NCH + 2;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     en;
  logic [NCH*16-1:0]        in_bus;
  logic [NCH*16-1:0]        gain_bus;
  logic signed [15:0]       out_w;
  logic                     out_valid_w;
  logic                     overrun_w;

  int in_a   [NCH];
  int gain_a [NCH];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Expected outputs as seen after each clock edge
  longint exp_out;
  bit     exp_valid;
  bit     exp_ovr;
  bit     pending;
  longint pend_val;
  longint due;
  longint mcyc = 0;

  tdm_audio_mixer #(.NUM_CHANNELS(NCH), .GAIN_FRAC_BITS(14)) dut (
    .clk          (clk),
    .I_RSTn       (rstn),
    .audio_clk_en (en),
    .in           (in_bus),
    .gain         (gain_bus),
    .out          (out_w),
    .out_valid    (out_valid_w),
    .overrun      (overrun_w)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_bus   = '0;
    gain_bus = '0;
    for (int k = 0; k < NCH; k++) begin
      in_bus[16*k +: 16]   = 16'(in_a[k]);
      gain_bus[16*k +: 16] = 16'(gain_a[k]);
    end
  end

  function automatic longint mix(input logic [NCH*16-1:0] iv, input logic [NCH*16-1:0] gv);
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k < NCH; k++) begin
      s += longint'($signed(iv[16*k +: 16])) * longint'($signed(gv[16*k +: 16]));
    end
    r = (s + 8192) >>> 14;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  // Model: one sample in flight; its result appears LAT edges after the strobe.
  always @(posedge clk) begin
    bit busy;
    mcyc++;
    if (!rstn) begin
      exp_out   = 0;
      exp_valid = 0;
      exp_ovr   = 0;
      pending   = 0;
    end else begin
      busy      = pending;
      exp_valid = 0;
      if (en) begin
        if (busy) exp_ovr = 1;
        else begin
          pend_val = mix(in_bus, gain_bus);
          due      = mcyc + LAT;
          pending  = 1;
        end
      end
      if (busy && mcyc == due) begin
        exp_out   = pend_val;
        exp_valid = 1;
        pending   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out_valid", longint'(out_valid_w), longint'(exp_valid));
      check("model_out", longint'(out_w), exp_out);
      check("model_overrun", longint'(overrun_w), longint'(exp_ovr));
    end
  end

  task automatic set_in(input int a, input int b, input int c, input int d);
    in_a[0] = a; in_a[1] = b; in_a[2] = c; in_a[3] = d;
  endtask

  task automatic set_gain(input int a, input int b, input int c, input int d);
    gain_a[0] = a; gain_a[1] = b; gain_a[2] = c; gain_a[3] = d;
  endtask

  task automatic strobe();
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
  endtask

  task automatic run_sample(input string name, input longint exp_v);
    int n;
    bit seen;
    strobe();
    n = 0;
    seen = 0;
    while (!seen && n <= 12) begin
      @(negedge clk);
      if (out_valid_w) seen = 1;
      else n++;
    end
    check({name, "_latency"}, seen ? longint'(n) : -1, LAT);
    check(name, longint'(out_w), exp_v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rstn = 1'b0;
    en   = 1'b0;
    set_in(0, 0, 0, 0);
    set_gain(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset_out", longint'(out_w), 0);
    check("reset_out_valid", longint'(out_valid_w), 0);
    check("reset_overrun", longint'(overrun_w), 0);
    rstn = 1'b1;

    set_in(16384, 0, 0, 0);   set_gain(16384, 0, 0, 0);
    run_sample("unity", 16384);
    @(negedge clk);
    check("unity_single_pulse", longint'(out_valid_w), 0);
    check("unity_out_hold", longint'(out_w), 16384);

    set_in(30000, 30000, 30000, 30000);     set_gain(16384, 16384, 16384, 16384);
    run_sample("sat_pos", 32767);
    set_in(-30000, -30000, -30000, -30000);
    run_sample("sat_neg", -32768);
    set_in(-32768, -32768, -32768, -32768); set_gain(-32768, -32768, -32768, -32768);
    run_sample("acc_no_wrap", 32767);

    set_in(1, 0, 0, 0);   set_gain(8192, 0, 0, 0);
    run_sample("round_half_pos", 1);
    set_in(-1, 0, 0, 0);
    run_sample("round_half_neg", 0);
    set_in(3, 0, 0, 0);   set_gain(-16384, 0, 0, 0);
    run_sample("round_neg_gain", -3);
    set_in(1000, -2000, 3000, 4000); set_gain(16384, 8192, -4096, 32767);
    run_sample("mixed_channels", 7250);

    // Snapshot isolation: in0 flips right after the strobe edge
    set_in(16384, 0, 0, 0); set_gain(16384, 0, 0, 0);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0; in_a[0] = -16384;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check("isolation_valid", longint'(out_valid_w), 1);
    check("isolation_first", longint'(out_w), 16384);
    run_sample("isolation_next", -16384);

    // Overrun: second strobe two cycles after the first is dropped
    set_in(5000, 0, 0, 0); set_gain(16384, 0, 0, 0);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0; in_a[0] = 7000;
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("overrun_set", longint'(overrun_w), 1);
    repeat (LAT - 3) @(posedge clk);
    @(negedge clk);
    check("overrun_valid", longint'(out_valid_w), 1);
    check("overrun_first_result", longint'(out_w), 5000);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid_w) pulses++;
    end
    check("overrun_no_second_pulse", pulses, 0);
    check("overrun_sticky", longint'(overrun_w), 1);

    // Reset mid-MAC aborts the sample
    set_in(1234, 0, 0, 0);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("midrst_out", longint'(out_w), 0);
    check("midrst_overrun", longint'(overrun_w), 0);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid_w) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    set_in(-700, 0, 0, 0);
    run_sample("after_reset", -700);
    check("after_reset_overrun", longint'(overrun_w), 0);

    // Strobe landing on the OUTPUT cycle is busy
    set_in(2000, 0, 0, 0);
    strobe();
    repeat (LAT - 1) @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
    check("edge_busy_valid", longint'(out_valid_w), 1);
    check("edge_busy_out", longint'(out_w), 2000);
    check("edge_busy_overrun", longint'(overrun_w), 1);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid_w) pulses++;
    end
    check("edge_busy_no_pulse", pulses, 0);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
